explosion_anim_ctrl: RTL

Upstream sequencer for the explosion sprite renderers. It accepts a trigger with a screen position and clamps that position to the screen. It then steps through the three explosion stages (explosion_1/2/3), holding each stage for a fixed number of video frames. For every DrawX/DrawY it produces the stage select, a per-pixel hit flag and the 32x32 sprite ROM address that feeds the stage ROM/palette stage downstream.

---
 rtl/explosion_anim_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/explosion_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : explosion_anim_ctrl
//  Purpose  : Sequencer for the explosion sprite renderers. Latches a clamped
//             sprite position on trigger, steps through NUM_STAGES animation
//             stages (FRAME_TICKS video frames each) and, for every pixel,
//             produces the stage select, a hit flag and the SPRITE_SIZE^2
//             sprite ROM address for the downstream ROM/palette stage.
//  Ports    :
//    vga_clk     in   1   pixel clock, rising edge
//    reset_n     in   1   asynchronous active-low reset
//    frame_start in   1   one-cycle pulse at the start of each video frame
//    trigger     in   1   one-cycle explosion request (honoured in IDLE only)
//    trig_x/y    in   10  requested sprite left/top edge, pixels
//    DrawX/Y     in   10  current pixel column/row
//    busy        out  1   high from accepted trigger until the last stage ends
//    stage       out  2   current stage index, selects renderer ROM
//    pixel_hit   out  1   current pixel lies inside the sprite box (1-cycle lat.)
//    rom_address out  10  {dy,dx} offset into the sprite when pixel_hit, else 0
//    done        out  1   one-cycle pulse when the animation finishes
//  Revision : 1.0 - initial release
// ============================================================================
module explosion_anim_ctrl #(
    parameter int FRAME_TICKS = 6,
    parameter int NUM_STAGES  = 3,
    parameter int SPRITE_SIZE = 32,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       trigger,
    input  logic [9:0] trig_x,
    input  logic [9:0] trig_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       busy,
    output logic [1:0] stage,
    output logic       pixel_hit,
    output logic [9:0] rom_address,
    output logic       done
);

    localparam int c_OFS_W  = $clog2(SPRITE_SIZE);
    localparam int c_TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(FRAME_TICKS - 1);
    localparam logic [1:0]          c_STAGE_LAST = 2'(NUM_STAGES - 1);
    localparam logic [9:0]          c_X_MAX      = 10'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [9:0]          c_Y_MAX      = 10'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0]         c_SIZE11     = 11'(SPRITE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    state_t              r_state;
    logic [9:0]          r_x0;
    logic [9:0]          r_y0;
    logic [c_TICK_W-1:0] r_tick;
    logic [1:0]          r_stage;
    logic                r_busy;
    logic                r_done;
    logic                r_pixel_hit;
    logic [9:0]          r_rom_address;

    // ------------------------------------------------------------------
    // Position clamp: keeps the whole sprite on screen.
    // ------------------------------------------------------------------
    logic [9:0] w_clamp_x;
    logic [9:0] w_clamp_y;

    assign w_clamp_x = (trig_x > c_X_MAX) ? c_X_MAX : trig_x;
    assign w_clamp_y = (trig_y > c_Y_MAX) ? c_Y_MAX : trig_y;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_tick  <= '0;
            r_stage <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A trigger coinciding with the done pulse belongs to the
                    // animation that just ended and is dropped.
                    if (trigger && !r_done) begin
                        r_x0    <= w_clamp_x;
                        r_y0    <= w_clamp_y;
                        r_busy  <= 1'b1;
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Wait for a frame boundary so stage 0 is never shown
                    // for a partial frame.
                    if (frame_start) begin
                        r_state <= ST_PLAY;
                        r_stage <= '0;
                        r_tick  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (frame_start) begin
                        if (r_tick != c_TICK_LAST) begin
                            r_tick <= r_tick + 1'b1;
                        end else if (r_stage != c_STAGE_LAST) begin
                            r_stage <= r_stage + 2'd1;
                            r_tick  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_stage <= '0;
                            r_tick  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hit test and ROM address. End-of-box sums are 11 bits wide so a box
    // near the right/bottom edge cannot wrap around.
    // ------------------------------------------------------------------
    logic [10:0]        w_x_end;
    logic [10:0]        w_y_end;
    logic               w_hit;
    logic [c_OFS_W-1:0] w_dx;
    logic [c_OFS_W-1:0] w_dy;

    assign w_x_end = {1'b0, r_x0} + c_SIZE11;
    assign w_y_end = {1'b0, r_y0} + c_SIZE11;
    assign w_hit   = (DrawX >= r_x0) && ({1'b0, DrawX} < w_x_end) &&
                     (DrawY >= r_y0) && ({1'b0, DrawY} < w_y_end);

    // Inside the box the offsets are below SPRITE_SIZE, so only the low
    // bits of the difference are needed.
    assign w_dx = DrawX[c_OFS_W-1:0] - r_x0[c_OFS_W-1:0];
    assign w_dy = DrawY[c_OFS_W-1:0] - r_y0[c_OFS_W-1:0];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_hit   <= 1'b0;
            r_rom_address <= '0;
        end else if ((r_state == ST_PLAY) && w_hit) begin
            r_pixel_hit   <= 1'b1;
            r_rom_address <= 10'({w_dy, w_dx});
        end else begin
            r_pixel_hit   <= 1'b0;
            r_rom_address <= '0;
        end
    end

    assign busy        = r_busy;
    assign stage       = r_stage;
    assign done        = r_done;
    assign pixel_hit   = r_pixel_hit;
    assign rom_address = r_rom_address;

endmodule
`default_nettype wire
